vga_timing_receiver: RTL and testbench
======================================

Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the team's VGA timing generator: samples a VGA stream (horiz_sync, vert_sync, vga_blank, R/G/B) on the pixel clock.
- Measures line and frame totals and recovers active-pixel coordinates.
- Declares lock once timing is stable; re-emits pixels with (x, y) and a valid strobe.
- Used as a loopback checker on the generator output and as a front end for frame capture.

Parameters:
- N, 9, counter MSB index; all count/coordinate outputs are N+1 bits wide (10 bits covers 800x525).
- SYNC_ACTIVE_LOW, 1, 1 = sync asserted when low (640x480 standard); 0 = asserted when high.
- LOCK_FRAMES, 2, consecutive matching frames needed to declare lock (range 1..7).

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- horiz_sync  in  1  incoming horizontal sync
- vert_sync  in  1  incoming vertical sync
- vga_blank  in  1  active-low blank: 1 = active pixel, 0 = blanking
- R, G, B  in  8 each  incoming colour
- pix_rgb  out  24  {B,G,R}: B in [23:16], G in [15:8], R in [7:0]
- pix_x, pix_y  out  N+1 each  active-area coordinate of pix_rgb
- pix_valid  out  1  pix_rgb/pix_x/pix_y valid this cycle
- line_start, frame_start  out  1 each  one-cycle pulses on hsync / vsync assertion edge
- h_total, v_total  out  N+1 each  last measured clocks/line, lines/frame
- locked  out  1  timing stable
- sync_error  out  1  one-cycle pulse on timing violation

Behaviour:
- Reset (reset=0, async): every output 0; all counters 0; FSM in SEARCH; input registers 0 (post-polarity: sync deasserted).
- Input stage: all inputs registered once. Sync is normalised by SYNC_ACTIVE_LOW, then edge-detected against a second register. "Assertion edge" = deasserted -> asserted.
- Latency: input sample to pix_* and to the pulses is exactly 2 clk cycles.
- Horizontal:
  - hcnt counts clk cycles, saturating at 2^(N+1)-1.
  - On hsync assertion edge: h_total <= hcnt+1, hcnt <= 0, line_start pulses.
- Active x: xcnt increments on each cycle with registered vga_blank=1. Cleared on hsync assertion edge. pix_x = xcnt before its increment.
- Active y:
  - line_active flag is set by any active pixel in the line.
  - On hsync assertion edge with line_active=1: ycnt++ and the flag clears.
  - On vsync assertion edge: ycnt <= 0.
  - pix_y = ycnt.
- Vertical:
  - lcnt increments on each hsync assertion edge, saturating.
  - On vsync assertion edge: v_total <= lcnt, lcnt <= 0, frame_start pulses.
  - Simultaneous hsync and vsync edges in one cycle: apply the hsync increment first, so v_total includes that line; then lcnt <= 0.
- pix_valid = registered vga_blank AND locked. pix_rgb is forwarded regardless of lock.
- Line check: at each hsync assertion edge, compare hcnt+1 with the previous h_total. A mismatch sets frame_bad (cleared at vsync edge).
- FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH: on first vsync assertion edge -> CHECK; match_cnt <= 0. Partial first frame ignored.
  - CHECK, at vsync edge:
    - If frame_bad=0 and lcnt+1 (or lcnt) equals stored v_total: match_cnt++; when match_cnt reaches LOCK_FRAMES -> LOCKED, locked=1 from the next cycle.
    - Otherwise match_cnt <= 0 and stay in CHECK.
  - LOCKED:
    - Line-length mismatch at an hsync edge, or v_total mismatch at a vsync edge: sync_error pulse, locked <= 0, -> CHECK, match_cnt <= 0.
  - Any state: hcnt or lcnt reaching saturation -> sync_error pulse (once per saturation event), locked <= 0, -> SEARCH.
- Reset mid-frame: immediate return to reset values; lock is re-acquired from scratch.

Decomposition:
- Package vga_rx_pkg holds:
  - typedef enum rx_state_t {SEARCH, CHECK, LOCKED}
  - constants H_TOTAL_640=800, V_TOTAL_480=525, H_ACTIVE_640=640, V_ACTIVE_480=480 for benches.
- One sub-module, sync_edge_detect: a two-register stage with polarity normalisation and an assertion-edge pulse output. Instantiated twice (hsync, vsync).

Test Plan:
1. Reset: pull reset low mid-line with the stream running -> within the same cycle all outputs 0, locked=0; release -> FSM in SEARCH.
2. Nominal 640x480 stream from the team's generator (800 clk/line, 525 lines):
   - After reset release: locked=1 after the 1+LOCK_FRAMES=3rd vsync edge.
   - h_total=800, v_total=525.
   - First valid pixel of a frame has pix_x=0, pix_y=0; last has pix_x=639, pix_y=479.
3. Data path: active pixel with R=0x12, G=0x34, B=0x56 -> two cycles later pix_rgb=0x563412, pix_valid=1.
4. While locked, stretch one line to 801 clocks -> sync_error pulses at that hsync edge; locked=0; re-lock after LOCK_FRAMES further clean frames.
5. Hold horiz_sync deasserted -> hcnt saturates at 1023 -> a single sync_error pulse, locked=0, FSM in SEARCH.
6. Coincident hsync and vsync assertion edges in one cycle -> v_total counts that line (525), lcnt=0, line_start and frame_start both pulse.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared types and reference timing constants for the VGA timing receiver.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam int unsigned H_TOTAL_640  = 800;
    localparam int unsigned V_TOTAL_480  = 525;
    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned V_ACTIVE_480 = 480;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a sync input, normalises its polarity and flags the
// deasserted -> asserted transition one cycle after sampling.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic assert_edge
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = ACTIVE_LOW ? ~sync_in : sync_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign assert_edge = s1_q & ~s2_q;

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA stream sink: measures line/frame totals, recovers active (x, y),
// declares lock after stable frames and re-emits pixels with a valid strobe.
module vga_timing_receiver
    import vga_rx_pkg::*;
#(
    parameter int unsigned N               = 9,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         horiz_sync,
    input  logic         vert_sync,
    input  logic         vga_blank,
    input  logic [7:0]   R,
    input  logic [7:0]   G,
    input  logic [7:0]   B,
    output logic [23:0]  pix_rgb,
    output logic [N:0]   pix_x,
    output logic [N:0]   pix_y,
    output logic         pix_valid,
    output logic         line_start,
    output logic         frame_start,
    output logic [N:0]   h_total,
    output logic [N:0]   v_total,
    output logic         locked,
    output logic         sync_error
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    function automatic logic [N:0] sat_inc(input logic [N:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    logic hs_edge, vs_edge;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk         (clk),
        .reset       (reset),
        .sync_in     (horiz_sync),
        .assert_edge (hs_edge)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk         (clk),
        .reset       (reset),
        .sync_in     (vert_sync),
        .assert_edge (vs_edge)
    );

    logic        blank_q;
    logic [23:0] rgb_q;
    logic [N:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [N:0]  xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic        line_active_q, line_active_d;
    logic        frame_bad_q, frame_bad_d;
    logic        first_q, first_d;
    logic [2:0]  match_q, match_d;
    rx_state_t   state_q, state_d;
    logic [23:0] pix_rgb_q;
    logic [N:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        pix_valid_q, pix_valid_d;
    logic        line_start_q, frame_start_q;
    logic [N:0]  h_total_q, h_total_d, v_total_q, v_total_d;
    logic        locked_q, locked_d;
    logic        sync_error_q, sync_error_d;

    logic [N:0]  h_meas, lcnt_inc, x_base;
    logic        line_mismatch, h_sat_evt, l_sat_evt;

    always_comb begin
        h_meas        = sat_inc(hcnt_q);
        // The line closing at a coincident hsync/vsync edge is still counted
        // into the frame that is being closed.
        lcnt_inc      = hs_edge ? sat_inc(lcnt_q) : lcnt_q;
        line_mismatch = hs_edge && (h_meas != h_total_q);

        hcnt_d    = hs_edge ? '0 : h_meas;
        h_total_d = hs_edge ? h_meas : h_total_q;
        lcnt_d    = vs_edge ? '0 : lcnt_inc;
        v_total_d = vs_edge ? lcnt_inc : v_total_q;
        h_sat_evt = (hcnt_d == '1) && (hcnt_q != '1);
        l_sat_evt = (lcnt_d == '1) && (lcnt_q != '1);

        x_base  = hs_edge ? '0 : xcnt_q;
        xcnt_d  = blank_q ? x_base + ONE : x_base;
        pix_x_d = x_base;

        ycnt_d        = ycnt_q;
        line_active_d = line_active_q | blank_q;
        if (hs_edge && line_active_q) begin
            ycnt_d        = ycnt_q + ONE;
            line_active_d = blank_q;
        end
        if (vs_edge) begin
            ycnt_d = '0;
        end
        pix_y_d = ycnt_q;

        frame_bad_d = vs_edge ? 1'b0 : (frame_bad_q | line_mismatch);

        state_d      = state_q;
        match_d      = match_q;
        first_d      = first_q;
        sync_error_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d = CHECK;
                    match_d = '0;
                    first_d = 1'b1;
                end
            end
            CHECK: begin
                // The first full frame has no trustworthy v_total reference
                // (the previous one was partial), so only its lines are judged.
                if (vs_edge) begin
                    if (!(frame_bad_q || line_mismatch) &&
                        (first_q || (lcnt_inc == v_total_q))) begin
                        match_d = match_q + 3'd1;
                        if (match_d >= 3'(LOCK_FRAMES)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                    first_d = 1'b0;
                end
            end
            LOCKED: begin
                if (line_mismatch || (vs_edge && (lcnt_inc != v_total_q))) begin
                    sync_error_d = 1'b1;
                    state_d      = CHECK;
                    match_d      = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (h_sat_evt || l_sat_evt) begin
            sync_error_d = 1'b1;
            state_d      = SEARCH;
            match_d      = '0;
        end
        locked_d    = (state_d == LOCKED);
        pix_valid_d = blank_q & locked_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_q       <= 1'b0;
            rgb_q         <= '0;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            line_active_q <= 1'b0;
            frame_bad_q   <= 1'b0;
            first_q       <= 1'b0;
            match_q       <= '0;
            state_q       <= SEARCH;
            pix_rgb_q     <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            locked_q      <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            blank_q       <= vga_blank;
            rgb_q         <= {B, G, R};
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            line_active_q <= line_active_d;
            frame_bad_q   <= frame_bad_d;
            first_q       <= first_d;
            match_q       <= match_d;
            state_q       <= state_d;
            pix_rgb_q     <= rgb_q;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            line_start_q  <= hs_edge;
            frame_start_q <= vs_edge;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            locked_q      <= locked_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign pix_rgb     = pix_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a reduced 16x8 raster
// (10x5 active, sync low-active, vsync edge coincident with hsync edge).
module tb_vga_timing_receiver;
    import vga_rx_pkg::*;

    localparam int HT = 16, HA = 10, HS0 = 12, HSW = 2;
    localparam int VT = 8, VA = 5, VS_LINE = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        horiz_sync = 1'b1, vert_sync = 1'b1, vga_blank = 1'b0;
    logic [7:0]  R = '0, G = '0, B = '0;
    logic [23:0] pix_rgb;
    logic [9:0]  pix_x, pix_y, h_total, v_total;
    logic        pix_valid, line_start, frame_start, locked, sync_error;

    vga_timing_receiver #(.N(9), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .vga_blank(vga_blank), .R(R), .G(G), .B(B), .pix_rgb(pix_rgb),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .line_start(line_start), .frame_start(frame_start), .h_total(h_total),
        .v_total(v_total), .locked(locked), .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } pix_t;

    pix_t pix_q[$];
    int   ls_q[$], fs_q[$], err_q[$];
    int   checks = 0, errors = 0;
    bit   prev_hs = 1'b0, prev_vs = 1'b0;
    int   last_hs_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_pulse(input string name, inout int q[$]);
        int e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: pulse at cycle %0d expected none", name, cyc);
        end else begin
            e = q.pop_front();
            if (e != cyc) begin
                errors++;
                $display("FAIL %s: pulse at cycle %0d expected cycle %0d", name, cyc, e);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin : monitor
        pix_t e;
        if (reset) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: x=%0d y=%0d rgb=0x%h at cycle %0d expected none",
                             pix_x, pix_y, pix_rgb, cyc);
                end else begin
                    e = pix_q.pop_front();
                    check("pix_cycle", 64'(cyc), 64'(e.cyc));
                    check("pix_x_y_rgb", 64'({pix_x, pix_y, pix_rgb}), 64'({e.x, e.y, e.rgb}));
                end
            end
            if (line_start)  pop_pulse("line_start", ls_q);
            if (frame_start) pop_pulse("frame_start", fs_q);
            if (sync_error)  pop_pulse("sync_error", err_q);
        end
    end

    task automatic drive(input bit hs_a, input bit vs_a, input bit bl,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input bit push_pix, input int x, input int y);
        pix_t p;
        horiz_sync = ~hs_a;
        vert_sync  = ~vs_a;
        vga_blank  = bl;
        R = r; G = g; B = b;
        if (hs_a && !prev_hs) begin
            ls_q.push_back(cyc + 2);
            last_hs_cyc = cyc;
        end
        if (vs_a && !prev_vs) fs_q.push_back(cyc + 2);
        if (push_pix) begin
            p.cyc = cyc + 2;
            p.x   = 10'(x);
            p.y   = 10'(y);
            p.rgb = {b, g, r};
            pix_q.push_back(p);
        end
        prev_hs = hs_a;
        prev_vs = vs_a;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_line();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_outs_a", 64'({pix_rgb, pix_x, pix_y}), 64'd0);
        check("rst_outs_b", 64'({pix_valid, line_start, frame_start, h_total, v_total,
                                 locked, sync_error}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(dut.state_q), 64'(SEARCH));
        @(negedge clk);
        #1 reset = 1'b1;
        prev_hs = 1'b0;
        prev_vs = 1'b0;
    endtask

    // lk_lines: pixels of lines below this are expected valid.
    task automatic run_frame(input int lk_lines, input int stretch_line, input int rst_line);
        int  len;
        bit  hs, vs, bl;
        logic [7:0] r, g, b;
        for (int ln = 0; ln < VT; ln++) begin
            len = (ln == stretch_line) ? HT + 1 : HT;
            for (int c = 0; c < len; c++) begin
                hs = (c >= HS0) && (c < HS0 + HSW);
                vs = ((ln == VS_LINE) && (c >= HS0)) || ((ln == VS_LINE + 1) && (c < HS0));
                bl = (ln < VA) && (c < HA);
                r = 8'(c * 7 + ln);
                g = 8'(ln * 29 + 3);
                b = 8'(c ^ 8'hA5);
                if (ln == 1 && c == 3) begin
                    r = 8'h12; g = 8'h34; b = 8'h56;
                end
                if (ln == rst_line && c == HS0) reset_mid_line();
                if (stretch_line >= 0 && ln == stretch_line + 1 && c == HS0)
                    err_q.push_back(cyc + 2);
                drive(hs, vs, bl, r, g, b, bl && (ln < lk_lines), c, ln);
            end
            if (ln == VS_LINE) check("lcnt_after_vsync", 64'(dut.lcnt_q), 64'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] sr, sg, sb;
        #1;
        check("reset_outs_a", 64'({pix_rgb, pix_x, pix_y}), 64'd0);
        check("reset_outs_b", 64'({pix_valid, line_start, frame_start, h_total, v_total,
                                   locked, sync_error}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(dut.state_q), 64'(SEARCH));
        @(negedge clk);
        #1 reset = 1'b1;

        // Acquisition: lock after the third vsync edge
        run_frame(0, -1, -1);  check("locked_f0", 64'(locked), 64'd0);
        run_frame(0, -1, -1);  check("locked_f1", 64'(locked), 64'd0);
        run_frame(0, -1, -1);  check("locked_f2", 64'(locked), 64'd1);
        check("h_total", 64'(h_total), 64'd16);
        check("v_total", 64'(v_total), 64'd8);
        run_frame(VT, -1, -1);

        // Stretched line while locked, then re-lock after two clean frames
        run_frame(4, 2, -1);
        check("locked_stretch", 64'(locked), 64'd0);
        check("state_stretch", 64'(dut.state_q), 64'(CHECK));
        run_frame(0, -1, -1);  check("locked_f5", 64'(locked), 64'd0);
        run_frame(0, -1, -1);  check("locked_f6", 64'(locked), 64'd1);
        run_frame(VT, -1, -1);

        // Missing hsync: hcnt saturates, one sync_error, back to SEARCH
        err_q.push_back(last_hs_cyc + 1025);
        sr = 8'h00; sg = 8'h00; sb = 8'h00;
        repeat (1100) drive(1'b0, 1'b0, 1'b0, sr, sg, sb, 1'b0, 0, 0);
        check("hcnt_sat", 64'(dut.hcnt_q), 64'd1023);
        check("locked_sat", 64'(locked), 64'd0);
        check("state_sat", 64'(dut.state_q), 64'(SEARCH));

        run_frame(0, -1, -1);
        run_frame(0, -1, -1);  check("locked_f9", 64'(locked), 64'd0);
        run_frame(0, -1, -1);  check("locked_f10", 64'(locked), 64'd1);

        // Reset mid-line while locked, then re-acquire from scratch
        run_frame(3, -1, 2);
        run_frame(0, -1, -1);  check("locked_f12", 64'(locked), 64'd0);
        run_frame(0, -1, -1);  check("locked_f13", 64'(locked), 64'd1);
        run_frame(VT, -1, -1);
        check("h_total_end", 64'(h_total), 64'd16);
        check("v_total_end", 64'(v_total), 64'd8);

        repeat (4) @(posedge clk);
        #1;
        check("pix_q_drained", 64'(pix_q.size()), 64'd0);
        check("ls_q_drained", 64'(ls_q.size()), 64'd0);
        check("fs_q_drained", 64'(fs_q.size()), 64'd0);
        check("err_q_drained", 64'(err_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
